// File: rtl/btn_pkg.sv
// Shared button-path definitions: FSM state encoding, default timing constants, count helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

  // Event generator FSM encoding; values are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // Default timing assumes a 100 MHz clk, shared with the debouncer.
  localparam int unsigned DEF_CNT_W         = 27;
  localparam int unsigned DEF_REPEAT_DELAY  = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10000000;
  localparam int unsigned DEF_LONG_PRESS    = 100000000;

  localparam int unsigned PRESS_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PRESS_CNT_W-1:0] sat_inc_cnt(input logic [PRESS_CNT_W-1:0] v);
    return (v == {PRESS_CNT_W{1'b1}}) ? v : v + PRESS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/button_event_gen_edge_detect.sv
// Edge detector: registers the previous level and flags rise/fall of the current level.
// Latency: rise/fall are combinational from din against a 1-cycle delayed copy.
// Backpressure: none; one strobe per level change, never stalled.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic prev_q;
  logic prev_d;

  // Next previous-level is simply the current sample.
  always_comb begin
    prev_d = din;
  end

  // Previous level clears on reset so a level already high reads as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;
  assign fall = ~din & prev_q;

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: press/repeat/release pulses, long-press level, saturating press count.
// Latency: every output is registered, one cycle after the sampled edge or timer tick.
// Backpressure: none; events are single-cycle pulses that consumers must catch.
module button_event_gen
  import btn_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned LONG_PRESS    = DEF_LONG_PRESS,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_db,
  output logic                   press_pulse,
  output logic                   repeat_pulse,
  output logic                   release_pulse,
  output logic                   long_press,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // Terminal timer values; the repeat timer reloads to 0 after each tick.
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(LONG_PRESS);

  logic rise;
  logic fall;

  btn_state_e             state_q,   state_d;
  logic [CNT_W-1:0]       rpt_q,     rpt_d;
  logic [CNT_W-1:0]       hold_q,    hold_d;
  logic [PRESS_CNT_W-1:0] cnt_q,     cnt_d;
  logic                   press_q,   press_d;
  logic                   repeat_q,  repeat_d;
  logic                   release_q, release_d;
  logic                   long_q,    long_d;
  logic [CNT_W-1:0]       hold_inc;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_db),
    .rise (rise),
    .fall (fall)
  );

  // Hold timer stops at the long-press threshold so it can never wrap.
  always_comb begin
    hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + CNT_W'(1);
  end

  // Next-state and event decode; release is checked before any repeat tick so it wins.
  always_comb begin
    state_d   = state_q;
    rpt_d     = rpt_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = sat_inc_cnt(cnt_q);
          rpt_d   = '0;
          hold_d  = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (fall) begin
          release_d = 1'b1;
          rpt_d     = '0;
          hold_d    = '0;
          state_d   = IDLE;
        end else if (btn_db) begin
          hold_d = hold_inc;
          if (rpt_q == DELAY_LAST) begin
            // With repeat disabled the timer parks here for the rest of the hold.
            if (REPEAT_EN) begin
              repeat_d = 1'b1;
              rpt_d    = '0;
              state_d  = REPEAT;
            end
          end else begin
            rpt_d = rpt_q + CNT_W'(1);
          end
        end
      end
      REPEAT: begin
        if (fall) begin
          release_d = 1'b1;
          rpt_d     = '0;
          hold_d    = '0;
          state_d   = IDLE;
        end else if (btn_db) begin
          hold_d = hold_inc;
          if (rpt_q == PERIOD_LAST) begin
            repeat_d = 1'b1;
            rpt_d    = '0;
          end else begin
            rpt_d = rpt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        rpt_d   = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
    // Long-press follows the next hold value, so it drops together with release_pulse.
    long_d = (hold_d == HOLD_MAX);
  end

  // State, timers and registered outputs; reset overrides any in-flight event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rpt_q     <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_q     <= rpt_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign press_pulse   = press_q;
  assign repeat_pulse  = repeat_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign press_count   = cnt_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen: two instances (repeat on/off) share one stimulus.
// Latency: reference model predicts the outputs visible after each sampling edge.
// Backpressure: none; the monitor compares every cycle plus queued directed checks.
module tb_button_event_gen;

  localparam int RD = 8;
  localparam int RP = 4;
  localparam int LP = 12;

  localparam int D_MARK = 0;
  localparam int D_CNT1 = 1;
  localparam int D_CNT0 = 2;
  localparam int D_PRS  = 3;
  localparam int D_REL  = 4;
  localparam int D_RPT1 = 5;
  localparam int D_RPT0 = 6;
  localparam int D_RPT0_TOTAL = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_db = 1'b0;
  logic       press_pulse, repeat_pulse, release_pulse, long_press;
  logic [7:0] press_count;
  logic       press_pulse_0, repeat_pulse_0, release_pulse_0, long_press_0;
  logic [7:0] press_count_0;

  button_event_gen #(
    .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .LONG_PRESS(LP), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_db(btn_db),
    .press_pulse(press_pulse), .repeat_pulse(repeat_pulse), .release_pulse(release_pulse),
    .long_press(long_press), .press_count(press_count)
  );

  button_event_gen #(
    .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .LONG_PRESS(LP), .REPEAT_EN(1'b0)
  ) dut_norpt (
    .clk(clk), .rst(rst), .btn_db(btn_db),
    .press_pulse(press_pulse_0), .repeat_pulse(repeat_pulse_0), .release_pulse(release_pulse_0),
    .long_press(long_press_0), .press_count(press_count_0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       press;
    logic       rpt1;
    logic       rel;
    logic       lng;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    int kind;
    int expv;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t dir_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int tot_press = 0, tot_rel = 0, tot_rpt1 = 0, tot_rpt0 = 0;
  int snap_press = 0, snap_rel = 0, snap_rpt1 = 0, snap_rpt0 = 0;

  // Reference model state: time since press, in sampled cycles.
  logic m_prev = 1'b0;
  logic m_held = 1'b0;
  int   m_age  = 0;
  int   m_cnt  = 0;

  function automatic logic tick_at(input int age);
    return (age >= RD) && (((age - RD) % RP) == 0);
  endfunction

  // Model: predict what each sampling edge should produce and queue it.
  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (rst) begin
      m_held = 1'b0;
      m_age  = 0;
      m_cnt  = 0;
    end else if (btn_db && !m_prev) begin
      e.press = 1'b1;
      m_held  = 1'b1;
      m_age   = 0;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (!btn_db && m_prev) begin
      e.rel  = 1'b1;
      m_held = 1'b0;
      m_age  = 0;
    end else if (m_held) begin
      m_age  = m_age + 1;
      e.rpt1 = tick_at(m_age);
      e.lng  = (m_age >= LP);
    end
    m_prev = rst ? 1'b0 : btn_db;
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
  end

  task automatic cmp(input string nm, input int act, input int req);
    n_cmp = n_cmp + 1;
    if (act != req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  // Monitor: directed checks first, then pop the model's prediction for this cycle.
  always @(negedge clk) begin
    exp_t  e;
    dchk_t d;
    logic [11:0] a1, a0, r1, r0;
    cyc = cyc + 1;
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      case (d.kind)
        D_MARK: begin
          snap_press = tot_press; snap_rel = tot_rel;
          snap_rpt1  = tot_rpt1;  snap_rpt0 = tot_rpt0;
        end
        D_CNT1: cmp("press_count_en1", int'(press_count), d.expv);
        D_CNT0: cmp("press_count_en0", int'(press_count_0), d.expv);
        D_PRS:  cmp("press_pulses_in_phase", tot_press - snap_press, d.expv);
        D_REL:  cmp("release_pulses_in_phase", tot_rel - snap_rel, d.expv);
        D_RPT1: cmp("repeat_pulses_in_phase_en1", tot_rpt1 - snap_rpt1, d.expv);
        D_RPT0: cmp("repeat_pulses_in_phase_en0", tot_rpt0 - snap_rpt0, d.expv);
        D_RPT0_TOTAL: cmp("repeat_pulses_total_en0", tot_rpt0, d.expv);
        default: ;
      endcase
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      a1 = {press_pulse, repeat_pulse, release_pulse, long_press, press_count};
      a0 = {press_pulse_0, repeat_pulse_0, release_pulse_0, long_press_0, press_count_0};
      r1 = {e.press, e.rpt1, e.rel, e.lng, e.cnt};
      r0 = {e.press, 1'b0, e.rel, e.lng, e.cnt};
      n_cmp = n_cmp + 2;
      if (a1 !== r1) begin
        n_bad = n_bad + 1;
        $display("FAIL outputs_en1 cyc=%0d actual{prs,rpt,rel,lng,cnt}=%h required=%h", cyc, a1, r1);
      end
      if (a0 !== r0) begin
        n_bad = n_bad + 1;
        $display("FAIL outputs_en0 cyc=%0d actual{prs,rpt,rel,lng,cnt}=%h required=%h", cyc, a0, r0);
      end
      if (press_pulse === 1'b1)    tot_press = tot_press + 1;
      if (release_pulse === 1'b1)  tot_rel   = tot_rel + 1;
      if (repeat_pulse === 1'b1)   tot_rpt1  = tot_rpt1 + 1;
      if (repeat_pulse_0 === 1'b1) tot_rpt0  = tot_rpt0 + 1;
    end
  end

  task automatic drive(input logic b, input logic r, input int n);
    btn_db = b;
    rst    = r;
    repeat (n) @(negedge clk);
  endtask

  task automatic dchk(input int kind, input int expv);
    dchk_t d;
    d.kind = kind;
    d.expv = expv;
    dir_q.push_back(d);
  endtask

  initial begin
    drive(1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 3);

    // Single tap.
    dchk(D_MARK, 0);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 4);
    dchk(D_CNT1, 1);
    dchk(D_CNT0, 1);
    dchk(D_RPT1, 0);
    dchk(D_REL, 1);

    // Hold 30 cycles: ticks at 8,12,...,28.
    dchk(D_MARK, 0);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 30);
    drive(1'b0, 1'b0, 4);
    dchk(D_RPT1, 6);
    dchk(D_REL, 1);

    // Release on the first repeat tick, immediate re-press, release on a later tick.
    dchk(D_MARK, 0);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 8);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 12);
    drive(1'b0, 1'b0, 4);
    dchk(D_RPT1, 1);
    dchk(D_PRS, 3);
    dchk(D_REL, 3);

    // Reset mid-hold with the button still down.
    dchk(D_MARK, 0);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 11);
    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b0, 5);
    dchk(D_CNT1, 1);
    dchk(D_CNT0, 1);
    dchk(D_REL, 0);
    drive(1'b0, 1'b0, 3);

    // Saturation: 260 one-cycle taps from a fresh reset.
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 2);
    dchk(D_MARK, 0);
    drive(1'b0, 1'b0, 1);
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b0, 1);
      drive(1'b0, 1'b0, 1);
    end
    drive(1'b0, 1'b0, 3);
    dchk(D_CNT1, 255);
    dchk(D_CNT0, 255);
    dchk(D_PRS, 260);
    dchk(D_REL, 260);

    // Hold 40 cycles: ticks at 8..36 with repeat on, none with it off.
    dchk(D_MARK, 0);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 40);
    drive(1'b0, 1'b0, 4);
    dchk(D_RPT1, 8);
    dchk(D_RPT0, 0);

    // Random presses, holds and occasional resets.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) drive(btn_db, 1'b1, 1);
      drive(1'b1, 1'b0, int'($urandom_range(1, 22)));
      drive(1'b0, 1'b0, int'($urandom_range(1, 5)));
    end

    drive(1'b0, 1'b0, 4);
    dchk(D_RPT0_TOTAL, 0);
    drive(1'b0, 1'b0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
